uart_rx: RTL
============

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD, default 9600, serial bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit, system clock, rising-edge active.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 The block SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-006 The block SHALL have port rx_data, output, 8 bits, last correctly received byte.
REQ-007 The block SHALL have port rx_done, output, 1 bit, one-clk pulse when rx_data has been updated.
REQ-008 The block SHALL have port rx_busy, output, 1 bit, high while a frame is in progress.
REQ-009 The block SHALL have port rx_err, output, 1 bit, one-clk pulse on a framing or parity error.

Function
REQ-010 rx SHALL pass through a 2-FF synchronizer; all decisions use the synchronized value.
REQ-011 A 16x oversample tick SHALL be generated every DIV = CLK_FREQ/(BAUD*16) clks (integer division; 651 at defaults), free-running from reset.
REQ-012 Frame format SHALL be: 1 start (0), 8 data bits LSB first, optional parity (see Configuration), 1 stop (1).
REQ-013 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-014 IDLE -> START SHALL occur when synchronized rx = 0; the tick counter within the bit resets to 0 at this point.
REQ-015 In START, at oversample count 7 (mid-bit): rx = 0 -> DATA with counter reset; rx = 1 -> IDLE (glitch rejected, no output pulse).
REQ-016 In DATA, each bit SHALL be sampled at count 15 after the previous sample point (mid-bit); after 8 bits -> PARITY if enabled, else STOP.
REQ-017 In STOP, at mid-bit: rx = 1 -> load rx_data, pulse rx_done, go IDLE; rx = 0 -> pulse rx_err, keep rx_data, go WAIT_IDLE.
REQ-018 WAIT_IDLE SHALL return to IDLE only once synchronized rx = 1 (break handling).
REQ-019 rx_done and rx_err SHALL be registered, high exactly one clk in the cycle after the stop/parity decision, and never high together.
REQ-020 rx_data SHALL change only in the same cycle rx_done rises and SHALL be held stable until the next rx_done.
REQ-021 rx_busy SHALL be 1 in every state except IDLE.
REQ-022 A new start bit SHALL be accepted immediately after the STOP-to-IDLE transition, so back-to-back frames are supported.

Reset
REQ-023 On rst, the FSM SHALL go to IDLE; rx_data = 8'h00; rx_done = rx_err = rx_busy = 0; the synchronizer flops = 1; all counters = 0.
REQ-024 A reset asserted mid-frame SHALL abort the frame without any rx_done or rx_err pulse.

Configuration
REQ-025 Macro UART_RX_PARITY_EN defined SHALL enable the PARITY state: one even-parity bit is sampled at mid-bit after the data bits. A mismatch pulses rx_err, does not update rx_data, and returns to IDLE after the stop bit is sampled. A match proceeds to STOP.
REQ-026 When UART_RX_PARITY_EN is undefined, the PARITY state and its logic SHALL be absent and DATA SHALL go directly to STOP.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state typedef, the OVERSAMPLE = 16 constant and the MID_SAMPLE = 7 constant.
REQ-028 The tick generator SHALL be a sub-module baud_tick_gen with parameters CLK_FREQ and BAUD and output tick.

Verification
REQ-029 The bench SHALL send 0x47 ('G') at 9600: one rx_done pulse, rx_data = 0x47, rx_err = 0, rx_busy falls with rx_done.
REQ-030 The bench SHALL drive rx low for 3 ticks, then high: no rx_done, no rx_err, FSM back in IDLE, rx_data unchanged.
REQ-031 The bench SHALL send 0x31 with stop bit = 0, after a prior byte 0x43: one rx_err pulse, rx_data stays 0x43, no rx_done until rx returns high and a new frame arrives.
REQ-032 The bench SHALL send 0x31 then 0x4D back-to-back with no idle gap: two rx_done pulses with rx_data = 0x31, then 0x4D.
REQ-033 The bench SHALL assert rst during data bit 4 of 0x55: no output pulses, all outputs at reset values, and the next frame 0x44 is received correctly.
REQ-034 With UART_RX_PARITY_EN, the bench SHALL send 0x55 with parity = 1 (wrong): an rx_err pulse and rx_data unchanged; with parity = 0, rx_done and rx_data = 0x55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver.
// Macro UART_RX_PARITY_EN adds the PARITY state to the FSM encoding.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 7;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running 16x oversample tick: one-clk pulse every CLK_FREQ/(BAUD*16) clks.
module baud_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIV_RAW = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int unsigned DIV     = (DIV_RAW == 0) ? 1 : DIV_RAW;
    localparam int unsigned CW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_w;

    always_comb begin
        tick_w = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_w ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_w;

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, 16x oversampled, 1 start / 8 data LSB first / 1 stop.
// Macro UART_RX_PARITY_EN adds an even-parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       rx_err
);

    localparam logic [3:0] MID_CNT  = 4'(MID_SAMPLE);
    localparam logic [3:0] LAST_CNT = 4'(OVERSAMPLE - 1);

    logic       tick;
    logic       sync1_q, sync2_q;
    logic       rx_s;

    rx_state_e  state_q, state_d;
    logic [3:0] os_cnt_q, os_cnt_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    logic       sample;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_q, par_bad_d;
`endif

    baud_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rx_s   = sync2_q;
    // The 4-bit counter wraps 15->0 by itself, so every sample point restarts the bit.
    assign sample = tick && (os_cnt_q == LAST_CNT);

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (tick && (state_q != IDLE) && (state_q != WAIT_IDLE)) begin
            os_cnt_d = os_cnt_q + 4'd1;
        end

        case (state_q)
            IDLE: begin
                os_cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (tick && (os_cnt_q == MID_CNT)) begin
                    os_cnt_d  = '0;
                    bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (sample) begin
                    par_bad_d = rx_s ^ (^shift_q);
                    state_d   = STOP;
                end
            end
`endif
            STOP: begin
                if (sample) begin
`ifdef UART_RX_PARITY_EN
                    if (rx_s && !par_bad_q) begin
`else
                    if (rx_s) begin
`endif
                        data_d  = shift_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = rx_s ? IDLE : WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign rx_data = data_q;
    assign rx_done = done_q;
    assign rx_err  = err_q;
    assign rx_busy = (state_q != IDLE);

endmodule
